// File: rtl/store_to_fetch_arbiter.sv
// store_to_fetch_arbiter
//   Round-robin arbiter that shares one store-to-fetch packet slot between
//   NUM_REQ store-side requesters and the fetch stage.
//
// Ports
//   clk          in   single clock, all state updates on rising edge
//   reset        in   asynchronous active-high reset
//   req_valid    in   [NUM_REQ]            requester i has a packet pending
//   req_pkt      in   [NUM_REQ*PKT_WIDTH]  packet of requester i at [i*PKT_WIDTH +: PKT_WIDTH]
//   req_grant    out  [NUM_REQ]            one-hot/zero, packet i accepted at this edge
//   can_receive  out  slot holds a packet for fetch
//   fetch_data   out  [PKT_WIDTH]          packet in slot
//   fetch_recv   in   fetch pops the slot this cycle
//   proto_error  out  sticky: pop seen while slot empty
//   pkt_count    out  [16]                 packets accepted since reset (wrapping)
module store_to_fetch_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PKT_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*PKT_WIDTH-1:0] req_pkt,
    output logic [NUM_REQ-1:0]           req_grant,
    output logic                         can_receive,
    output logic [PKT_WIDTH-1:0]         fetch_data,
    input  logic                         fetch_recv,
    output logic                         proto_error,
    output logic [15:0]                  pkt_count
);

    localparam int              PTR_W     = $clog2(NUM_REQ);
    localparam logic [PTR_W:0]  NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                 state_q;
    logic [PTR_W-1:0]       rr_q;
    logic [PTR_W-1:0]       rr_d;
    logic [PKT_WIDTH-1:0]   data_q;
    logic                   proto_q;
    logic [15:0]            count_q;

    logic                   writable;
    logic                   grant_any;
    logic [PTR_W-1:0]       grant_idx;

    // Search upward from rr_q, wrapping at NUM_REQ; first valid requester wins.
    always_comb begin
        logic [PTR_W:0] cand;
        cand      = '0;
        req_grant = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        writable  = (state_q == EMPTY) || fetch_recv;
        if (!reset && writable) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = {1'b0, rr_q} + k[PTR_W:0];
                if (cand >= NUM_REQ_W) begin
                    cand = cand - NUM_REQ_W;
                end
                if (!grant_any && req_valid[cand[PTR_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = cand[PTR_W-1:0];
                end
            end
        end
        if (grant_any) begin
            req_grant[grant_idx] = 1'b1;
        end
        rr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            rr_q    <= '0;
            data_q  <= '0;
            proto_q <= 1'b0;
            count_q <= '0;
        end else begin
            if (grant_any) begin
                // Covers both fill-from-empty and pop-and-refill.
                data_q  <= req_pkt[int'(grant_idx)*PKT_WIDTH +: PKT_WIDTH];
                state_q <= FULL;
                rr_q    <= rr_d;
                count_q <= count_q + 16'd1;
            end else if (state_q == FULL && fetch_recv) begin
                state_q <= EMPTY;
            end
            if (state_q == EMPTY && fetch_recv) begin
                proto_q <= 1'b1;
            end
        end
    end

    assign can_receive = (state_q == FULL);
    assign fetch_data  = data_q;
    assign proto_error = proto_q;
    assign pkt_count   = count_q;

endmodule

// File: tb/tb_store_to_fetch_arbiter.sv
module tb_store_to_fetch_arbiter;

    localparam int N = 4;
    localparam int W = 64;
    localparam int SV_W = 1 + W + 1 + 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_pkt;
    logic [N-1:0]   req_grant;
    logic           can_receive;
    logic [W-1:0]   fetch_data;
    logic           fetch_recv;
    logic           proto_error;
    logic [15:0]    pkt_count;

    always #5 clk = ~clk;

    store_to_fetch_arbiter #(.NUM_REQ(N), .PKT_WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_pkt     (req_pkt),
        .req_grant   (req_grant),
        .can_receive (can_receive),
        .fetch_data  (fetch_data),
        .fetch_recv  (fetch_recv),
        .proto_error (proto_error),
        .pkt_count   (pkt_count)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: slot occupancy, slot contents, pointer, sticky flag, counter.
    bit           m_full;
    int           m_ptr;
    logic [W-1:0] m_data;
    bit           m_proto;
    int           m_count;

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] g;
        g = '0;
        if (reset) return g;
        if (m_full && !fetch_recv) return g;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic logic [SV_W-1:0] m_state();
        logic [15:0] c;
        c = 16'(m_count);
        return {m_full, m_data, m_proto, c};
    endfunction

    function automatic logic [SV_W-1:0] dut_state();
        return {can_receive, fetch_data, proto_error, pkt_count};
    endfunction

    task automatic m_reset();
        m_full  = 0;
        m_ptr   = 0;
        m_data  = '0;
        m_proto = 0;
        m_count = 0;
    endtask

    // One rising edge for both DUT and model; leaves time at posedge+1.
    task automatic advance();
        logic [N-1:0] g;
        bit was_full;
        bit fr;
        g        = m_grant();
        was_full = m_full;
        fr       = fetch_recv;
        @(posedge clk);
        if (g != '0) begin
            for (int k = 0; k < N; k++) begin
                if (g[k]) begin
                    m_data = req_pkt[k*W +: W];
                    m_ptr  = (k + 1) % N;
                end
            end
            m_full  = 1;
            m_count = (m_count + 1) % 65536;
        end else if (was_full && fr) begin
            m_full = 0;
        end
        if (!was_full && fr) m_proto = 1;
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic fr);
        @(negedge clk);
        req_valid  = v;
        fetch_recv = fr;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset      = 1'b1;
        req_valid  = '0;
        fetch_recv = 1'b0;
        m_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        req_valid  = '1;
        fetch_recv = 1'b0;
        for (int k = 0; k < N; k++) req_pkt[k*W +: W] = {$urandom, $urandom};
        m_reset();
        repeat (2) @(negedge clk);
        n_total++;
        if (req_grant !== '0) $display("FAIL reset_grant: got %b want 0000", req_grant);
        else n_pass++;
        n_total++;
        if (dut_state() !== m_state()) $display("FAIL reset_state: got %h want %h", dut_state(), m_state());
        else n_pass++;
        reset     = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_first_packet();
        req_pkt[0 +: W] = 64'hAAAA;
        drive(4'b0001, 1'b0);
        n_total++;
        if (req_grant !== 4'b0001) $display("FAIL first_grant: got %b want 0001", req_grant);
        else n_pass++;
        advance();
        n_total++;
        if ({can_receive, fetch_data, pkt_count} !== {1'b1, 64'hAAAA, 16'd1})
            $display("FAIL first_visible: got %b/%h/%0d want 1/aaaa/1", can_receive, fetch_data, pkt_count);
        else n_pass++;
    endtask

    task automatic test_hold_full();
        logic [W-1:0] p1;
        p1 = {$urandom, $urandom};
        req_pkt[W +: W] = p1;
        for (int c = 0; c < 3; c++) begin
            drive(4'b0010, 1'b0);
            n_total++;
            if (req_grant !== 4'b0000) $display("FAIL hold_grant c%0d: got %b want 0000", c, req_grant);
            else n_pass++;
            advance();
            n_total++;
            if ({can_receive, fetch_data} !== {1'b1, 64'hAAAA})
                $display("FAIL hold_data c%0d: got %b/%h want 1/aaaa", c, can_receive, fetch_data);
            else n_pass++;
        end
        drive(4'b0010, 1'b1);
        n_total++;
        if (req_grant !== 4'b0010) $display("FAIL hold_pop_grant: got %b want 0010", req_grant);
        else n_pass++;
        advance();
        n_total++;
        if ({can_receive, fetch_data, pkt_count} !== {1'b1, p1, 16'd2})
            $display("FAIL hold_refill: got %b/%h/%0d want 1/%h/2", can_receive, fetch_data, pkt_count, p1);
        else n_pass++;
    endtask

    // Pointer is 2 after granting requester 1; only 0 and 1 request.
    task automatic test_rr_wrap();
        drive(4'b0011, 1'b1);
        n_total++;
        if (req_grant !== 4'b0001) $display("FAIL wrap_grant0: got %b want 0001", req_grant);
        else n_pass++;
        advance();
        drive(4'b0011, 1'b1);
        n_total++;
        if (req_grant !== 4'b0010) $display("FAIL wrap_grant1: got %b want 0010", req_grant);
        else n_pass++;
        advance();
        n_total++;
        if (dut_state() !== m_state()) $display("FAIL wrap_state: got %h want %h", dut_state(), m_state());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int order [5] = '{0, 1, 2, 3, 0};
        int seen [N];
        logic [N-1:0] e;
        apply_reset();
        for (int k = 0; k < N; k++) begin
            req_pkt[k*W +: W] = {$urandom, $urandom};
            seen[k] = 0;
        end
        for (int i = 0; i < 5; i++) begin
            drive('1, m_full);
            e = '0;
            e[order[i]] = 1'b1;
            n_total++;
            if (req_grant !== e) $display("FAIL b2b_grant %0d: got %b want %b", i, req_grant, e);
            else n_pass++;
            for (int k = 0; k < N; k++) if (i < 4 && req_grant[k]) seen[k]++;
            advance();
            n_total++;
            if (dut_state() !== m_state()) $display("FAIL b2b_state %0d: got %h want %h", i, dut_state(), m_state());
            else n_pass++;
        end
        for (int k = 0; k < N; k++) begin
            n_total++;
            if (seen[k] != 1) $display("FAIL b2b_fair req%0d: got %0d grants want 1", k, seen[k]);
            else n_pass++;
        end
    endtask

    task automatic test_proto_error();
        logic [N-1:0] pv [4] = '{4'b0000, 4'b0100, 4'b0000, 4'b1000};
        logic         pf [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(pv[i], pf[i]);
            n_total++;
            if (req_grant !== m_grant()) $display("FAIL proto_grant %0d: got %b want %b", i, req_grant, m_grant());
            else n_pass++;
            advance();
            n_total++;
            if (proto_error !== 1'b1 || dut_state() !== m_state())
                $display("FAIL proto_sticky %0d: got %h want %h", i, dut_state(), m_state());
            else n_pass++;
        end
        apply_reset();
        n_total++;
        if (proto_error !== 1'b0) $display("FAIL proto_clear: got %b want 0", proto_error);
        else n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) req_pkt[k*W +: W] = {$urandom, $urandom};
            drive(N'($urandom), 1'($urandom_range(0, 1)));
            n_total++;
            if (req_grant !== m_grant()) $display("FAIL rand_grant %0d: got %b want %b", i, req_grant, m_grant());
            else n_pass++;
            advance();
            n_total++;
            if (dut_state() !== m_state()) $display("FAIL rand_state %0d: got %h want %h", i, dut_state(), m_state());
            else n_pass++;
        end
    endtask

    task automatic test_reset_midtransfer();
        apply_reset();
        req_pkt[3*W +: W] = {$urandom, $urandom};
        drive(4'b1000, 1'b0);
        advance();
        drive('1, 1'b1);
        #1;
        reset = 1'b1;
        m_reset();
        #1;
        n_total++;
        if ({can_receive, fetch_data, req_grant} !== {1'b1 ^ 1'b1, 64'h0, 4'b0000})
            $display("FAIL midreset: got %b/%h/%b want 0/0/0000", can_receive, fetch_data, req_grant);
        else n_pass++;
        @(negedge clk);
        reset      = 1'b0;
        req_valid  = '0;
        fetch_recv = 1'b0;
        drive('1, 1'b0);
        n_total++;
        if (req_grant !== 4'b0001) $display("FAIL midreset_restart: got %b want 0001", req_grant);
        else n_pass++;
        advance();
    endtask

    task automatic test_count_wrap();
        apply_reset();
        req_pkt[0 +: W] = 64'h1234;
        for (int i = 0; i < 65535; i++) begin
            drive(4'b0001, m_full);
            advance();
        end
        n_total++;
        if (pkt_count !== 16'hFFFF) $display("FAIL count_max: got %h want ffff", pkt_count);
        else n_pass++;
        drive(4'b0001, 1'b1);
        advance();
        n_total++;
        if (pkt_count !== 16'h0000 || dut_state() !== m_state())
            $display("FAIL count_wrap: got %h want 0000", pkt_count);
        else n_pass++;
        drive(4'b0000, 1'b0);
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        n_total++;
        if ({can_receive, fetch_data} !== {1'b0, 64'h0})
            $display("FAIL full_reset: got %b/%h want 0/0", can_receive, fetch_data);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        fetch_recv = 1'b0;
        req_pkt    = '0;
        test_reset();
        test_first_packet();
        test_hold_full();
        test_rr_wrap();
        test_back_to_back();
        test_proto_error();
        test_random();
        test_reset_midtransfer();
        test_count_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/store_to_fetch_arbiter.md
# store_to_fetch_arbiter

Shares the single-entry store-to-fetch mailbox between several store-side requesters (store unit, branch-resolve, exception redirect) and the fetch stage. Holds one packet slot with the same semantics as the store-to-fetch bus: a sender may only write when the slot is empty, and the fetch stage consumes it by popping. The arbiter picks one requester per cycle with a round-robin policy, registers the winning packet, and flags protocol violations on the fetch side. It sits between the store stage outputs and the fetch stage input.

## Interface
- NUM_REQ, 4: number of requesters; 2..8.
- PKT_WIDTH, 64: width of one StoreToFetchPacket in bits.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  NUM_REQ  requester i has a packet to send; held until granted.
- req_pkt  in  NUM_REQ*PKT_WIDTH  packet of requester i in bits [i*PKT_WIDTH +: PKT_WIDTH]; stable while req_valid.
- req_grant  out  NUM_REQ  one-hot or zero; bit i high = requester i's packet is accepted at this edge.
- can_receive  out  1  slot holds a packet for fetch (registered).
- fetch_data  out  PKT_WIDTH  packet in slot (registered); valid when can_receive.
- fetch_recv  in  1  fetch pops slot this cycle.
- proto_error  out  1  sticky: fetch_recv asserted while can_receive low.
- pkt_count  out  16  packets accepted since reset; wraps 0xFFFF -> 0x0000.

## Operation
- States: EMPTY (can_receive=0), FULL (can_receive=1).
- Slot is writable this cycle when state is EMPTY, or FULL with fetch_recv=1 (pop and refill in the same cycle).
- When writable and any req_valid set: grant the first requester with req_valid set searching from rr_ptr upward modulo NUM_REQ; req_grant combinational in the same cycle.
- On a grant to i: fetch_data <= req_pkt[i]; state -> FULL; rr_ptr <= (i+1) mod NUM_REQ; pkt_count <= pkt_count+1.
- No grant when not writable; req_grant = 0; rr_ptr unchanged.
- FULL, fetch_recv=1, no req_valid: state -> EMPTY; fetch_data holds last value.
- FULL, fetch_recv=0: state and data held regardless of requests.
- EMPTY, fetch_recv=1: proto_error <= 1 (sticky until reset); state unchanged; any simultaneous grant still proceeds normally.
- rr_ptr is the only fairness state: a requester holding req_valid is granted within NUM_REQ writable cycles.
- Requester dropping req_valid before grant is legal; no state retained for it.
- Reset values: state EMPTY, can_receive 0, fetch_data 0, rr_ptr 0, proto_error 0, pkt_count 0; req_grant 0 while reset high.

## Timing
- Request-to-visible latency: 1 cycle (grant at edge N, can_receive/fetch_data valid after edge N).
- Back-to-back throughput: 1 packet/cycle when fetch pops every cycle.
- req_grant depends combinationally on req_valid, fetch_recv, state and rr_ptr; no other combinational paths to outputs.
- fetch_data/can_receive change only on clock edges or asynchronously on reset.
- Reset asserted mid-transfer: slot content discarded, no grant issued that cycle; after deassertion arbitration restarts at requester 0.

## Test plan
- Reset, then req_valid=0001, pkt0=0xAAAA -> req_grant=0001 same cycle; next cycle can_receive=1, fetch_data=0xAAAA, pkt_count=1.
- Slot FULL, fetch_recv=0, req_valid=0010 held 3 cycles -> req_grant=0 all 3 cycles, fetch_data unchanged; on pop cycle req_grant=0010, next cycle fetch_data=pkt1.
- All four requesters valid continuously, fetch_recv=1 every FULL cycle -> grants in order 0,1,2,3,0 on consecutive cycles; each requester exactly once per 4 grants.
- rr_ptr=2, req_valid=0011 -> grant requester 0, then rr_ptr=1 -> next grant requester 1.
- fetch_recv=1 while EMPTY -> proto_error=1 next cycle and stays 1 through later traffic; clears only on reset.
- Force pkt_count=0xFFFF via 65535 grants, one more grant -> pkt_count=0x0000; assert reset while FULL -> can_receive=0, fetch_data=0 immediately.
